ysyx_2022040010_icache_refill: RTL and testbench

YSYX_2022040010_ICACHE_REFILL -- requirements
Module: ysyx_2022040010_icache_refill

---
 rtl/ysyx_2022040010_icache_refill.sv | 145 ++++++++++++++
 tb/tb_ysyx_2022040010_icache_refill.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_2022040010_icache_refill.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_2022040010_icache_refill
// Purpose  : Instruction-cache miss refill engine. On a tag-stage miss it
//            issues one single-beat AXI-style read for the 64-bit line. It then
//            writes the returned line into the victim way of the data array,
//            updates tag/LRU through a refresh pulse and bypasses the line to
//            fetch. Only one request is outstanding at a time.
// Ports    : clk, rst               - clock, synchronous active-high reset
//            miss, lru, sram_addr   - miss request, victim way, fetch address
//            flush                  - pipeline flush (suppresses the refill)
//            arvalid/arready/araddr/arlen/arsize - read-address channel
//            rvalid/rready/rdata/rresp           - read-data channel
//            refresh                - one-cycle tag/LRU update pulse
//            data_we/data_index/data_wdata       - data-array write port
//            refill_valid/refill_data            - bypass to fetch
//            busy, err              - engine active / bus error pulse
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_2022040010_icache_refill #(
    parameter int ADDR_WIDTH   = 64,
    parameter int INDEX_WIDTH  = 6,
    parameter int OFFSET_WIDTH = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   miss,
    input  logic                   lru,
    input  logic [ADDR_WIDTH-1:0]  sram_addr,
    input  logic                   flush,
    output logic                   arvalid,
    input  logic                   arready,
    output logic [ADDR_WIDTH-1:0]  araddr,
    output logic [7:0]             arlen,
    output logic [2:0]             arsize,
    input  logic                   rvalid,
    output logic                   rready,
    input  logic [63:0]            rdata,
    input  logic [1:0]             rresp,
    output logic                   refresh,
    output logic [1:0]             data_we,
    output logic [INDEX_WIDTH-1:0] data_index,
    output logic [63:0]            data_wdata,
    output logic                   refill_valid,
    output logic [63:0]            refill_data,
    output logic                   busy,
    output logic                   err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_AR   = 2'd1,
        S_R    = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] c_RESP_OKAY = 2'b00;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [ADDR_WIDTH-1:0]  r_araddr;
    logic [INDEX_WIDTH-1:0] r_index;
    logic                   r_victim;
    logic [63:0]            r_rdata;
    logic                   r_flush_pend;
    logic                   r_err;

    logic w_beat;
    logic w_resp_ok;
    logic w_flush_seen;
    logic w_unused_addr_lo;

    // Byte-offset bits are dropped because the request is line aligned.
    assign w_unused_addr_lo = ^sram_addr[OFFSET_WIDTH-1:0];

    assign w_beat       = (r_state == S_R) && rvalid;
    assign w_resp_ok    = (rresp == c_RESP_OKAY);
    // A flush arriving on the beat cycle itself must still cancel the refill.
    assign w_flush_seen = r_flush_pend || flush;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (miss)    w_state_nxt = S_AR;
            S_AR:   if (arready) w_state_nxt = S_R;
            S_R: begin
                if (rvalid) begin
                    if (w_resp_ok && !w_flush_seen) w_state_nxt = S_DONE;
                    else                            w_state_nxt = S_IDLE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_araddr     <= '0;
            r_index      <= '0;
            r_victim     <= 1'b0;
            r_rdata      <= '0;
            r_flush_pend <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_beat && !w_resp_ok;

            if ((r_state == S_IDLE) && miss) begin
                r_araddr <= {sram_addr[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
                r_index  <= sram_addr[OFFSET_WIDTH+INDEX_WIDTH-1:OFFSET_WIDTH];
                r_victim <= lru;
            end

            if (w_beat) begin
                r_rdata <= rdata;
            end

            // The flag lives for one request; it is dropped whenever the
            // engine heads back to IDLE so it cannot leak into the next miss.
            if (w_state_nxt == S_IDLE) begin
                r_flush_pend <= 1'b0;
            end else if (((r_state == S_AR) || (r_state == S_R)) && flush) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

    assign arvalid      = (r_state == S_AR);
    assign araddr       = r_araddr;
    assign arlen        = 8'd0;
    assign arsize       = 3'd3;
    assign rready       = (r_state == S_R);
    assign refresh      = (r_state == S_DONE);
    assign data_we      = (r_state == S_DONE) ? (r_victim ? 2'b10 : 2'b01) : 2'b00;
    assign data_index   = r_index;
    assign data_wdata   = r_rdata;
    assign refill_valid = (r_state == S_DONE);
    assign refill_data  = r_rdata;
    assign busy         = (r_state != S_IDLE);
    assign err          = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_2022040010_icache_refill.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_2022040010_icache_refill
// Purpose  : Directed bench for the icache refill engine. The driver issues
//            misses and plays the bus; each expected address handshake and
//            write-back/error event is queued, and a monitor pops and compares
//            whenever the DUT presents one.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_2022040010_icache_refill;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss;
    logic        lru;
    logic [63:0] sram_addr;
    logic        flush;
    logic        arvalid;
    logic        arready;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic        rvalid;
    logic        rready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        refresh;
    logic [1:0]  data_we;
    logic [5:0]  data_index;
    logic [63:0] data_wdata;
    logic        refill_valid;
    logic [63:0] refill_data;
    logic        busy;
    logic        err;

    always #5 clk = ~clk;

    ysyx_2022040010_icache_refill #(
        .ADDR_WIDTH  (64),
        .INDEX_WIDTH (6),
        .OFFSET_WIDTH(3)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .miss        (miss),
        .lru         (lru),
        .sram_addr   (sram_addr),
        .flush       (flush),
        .arvalid     (arvalid),
        .arready     (arready),
        .araddr      (araddr),
        .arlen       (arlen),
        .arsize      (arsize),
        .rvalid      (rvalid),
        .rready      (rready),
        .rdata       (rdata),
        .rresp       (rresp),
        .refresh     (refresh),
        .data_we     (data_we),
        .data_index  (data_index),
        .data_wdata  (data_wdata),
        .refill_valid(refill_valid),
        .refill_data (refill_data),
        .busy        (busy),
        .err         (err)
    );

    typedef struct {
        logic        is_err;
        logic [1:0]  we;
        logic [5:0]  idx;
        logic [63:0] data;
    } exp_t;

    logic [63:0] ar_q[$];
    exp_t        ev_q[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: checks every address handshake and every write-back/error.
    always @(negedge clk) begin
        if (!rst) begin
            if (arvalid && arready) begin
                if (ar_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL ar_unexpected: got araddr %h expected no handshake", araddr);
                end else begin
                    chk("ar_addr", araddr, ar_q.pop_front());
                    chk("ar_len", {56'd0, arlen}, 64'd0);
                    chk("ar_size", {61'd0, arsize}, 64'd3);
                end
            end
            if (refresh || err) begin
                if (ev_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL ev_unexpected: got refresh=%0b err=%0b expected none", refresh, err);
                end else begin
                    exp_t e;
                    e = ev_q.pop_front();
                    chk("ev_err", {63'd0, err}, {63'd0, e.is_err});
                    chk("ev_refresh", {63'd0, refresh}, {63'd0, !e.is_err});
                    chk("ev_refill_valid", {63'd0, refill_valid}, {63'd0, !e.is_err});
                    chk("ev_data_we", {62'd0, data_we}, {62'd0, e.we});
                    if (!e.is_err) begin
                        chk("ev_index", {58'd0, data_index}, {58'd0, e.idx});
                        chk("ev_wdata", data_wdata, e.data);
                        chk("ev_refill_data", refill_data, e.data);
                    end
                end
            end
        end
    end

    // One complete miss. Called one step after a rising edge with the DUT idle.
    task automatic bus_req(input logic [63:0] addr, input logic lru_i,
                           input logic [63:0] exp_araddr, input logic [5:0] exp_idx,
                           input int ar_wait, input int r_wait,
                           input logic [63:0] d, input logic [1:0] resp,
                           input bit flush_r);
        exp_t e;
        ar_q.push_back(exp_araddr);
        if (resp != 2'b00) begin
            e.is_err = 1'b1; e.we = 2'b00; e.idx = 6'd0; e.data = 64'd0;
            ev_q.push_back(e);
        end else if (!flush_r) begin
            e.is_err = 1'b0; e.we = lru_i ? 2'b10 : 2'b01; e.idx = exp_idx; e.data = d;
            ev_q.push_back(e);
        end
        miss = 1'b1; sram_addr = addr; lru = lru_i;
        tick();
        miss = 1'b0;
        for (int i = 0; i < ar_wait; i++) begin
            chk("ar_hold_valid", {63'd0, arvalid}, 64'd1);
            chk("ar_hold_addr", araddr, exp_araddr);
            chk("ar_hold_busy", {63'd0, busy}, 64'd1);
            tick();
        end
        arready = 1'b1;
        tick();
        arready = 1'b0;
        for (int i = 0; i < r_wait; i++) begin
            chk("r_wait_rready", {63'd0, rready}, 64'd1);
            flush = flush_r && (i == 0);
            tick();
            flush = 1'b0;
        end
        chk("r_rready", {63'd0, rready}, 64'd1);
        if (r_wait == 0) flush = flush_r;
        rvalid = 1'b1; rdata = d; rresp = resp;
        tick();
        rvalid = 1'b0; rresp = 2'b00; rdata = 64'hBAD0_BAD0_BAD0_BAD0; flush = 1'b0;
        if (resp == 2'b00 && !flush_r) begin
            chk("done_refresh", {63'd0, refresh}, 64'd1);
        end else begin
            chk("abort_busy", {63'd0, busy}, 64'd0);
            chk("abort_refresh", {63'd0, refresh}, 64'd0);
            chk("abort_we", {62'd0, data_we}, 64'd0);
            chk("abort_err", {63'd0, err}, {63'd0, resp != 2'b00});
        end
        tick();
        chk("post_idle_busy", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst = 1'b1; miss = 1'b0; lru = 1'b0; sram_addr = '0; flush = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        repeat (3) tick();

        chk("rst_arvalid", {63'd0, arvalid}, 64'd0);
        chk("rst_rready", {63'd0, rready}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_refresh", {63'd0, refresh}, 64'd0);
        chk("rst_we", {62'd0, data_we}, 64'd0);
        chk("rst_refill_valid", {63'd0, refill_valid}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_araddr", araddr, 64'd0);
        chk("rst_wdata", data_wdata, 64'd0);
        chk("rst_refill_data", refill_data, 64'd0);
        chk("rst_index", {58'd0, data_index}, 64'd0);
        rst = 1'b0;
        tick();

        // Basic refill with immediate handshakes: DONE three cycles after miss.
        bus_req(64'h8000_0014, 1'b1, 64'h8000_0010, 6'd2, 0, 0, 64'h0011_2233_4455_6677, 2'b00, 0);
        // arready stalled five cycles.
        bus_req(64'h8000_123F, 1'b0, 64'h8000_1238, 6'd7, 5, 0, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 0);
        // Flush in R, beat two cycles later: consumed but no write-back.
        bus_req(64'h8000_0100, 1'b0, 64'h8000_0100, 6'd32, 0, 2, 64'h1111_2222_3333_4444, 2'b00, 1);
        // Error response.
        bus_req(64'h8000_0200, 1'b1, 64'h8000_0200, 6'd0, 1, 1, 64'h9999_8888_7777_6666, 2'b10, 0);
        // Next miss after the error is serviced normally.
        bus_req(64'h8000_01F8, 1'b1, 64'h8000_01F8, 6'd63, 0, 3, 64'h0123_4567_89AB_CDEF, 2'b00, 0);
        // Back-to-back misses at indices 5 and 6.
        bus_req(64'h8000_0028, 1'b0, 64'h8000_0028, 6'd5, 0, 0, 64'hAAAA_AAAA_AAAA_AAAA, 2'b00, 0);
        bus_req(64'h8000_0030, 1'b1, 64'h8000_0030, 6'd6, 0, 0, 64'h5555_5555_5555_5555, 2'b00, 0);
        // Flush coincident with the data beat.
        bus_req(64'h8000_0040, 1'b0, 64'h8000_0040, 6'd8, 0, 0, 64'h7777_7777_7777_7777, 2'b00, 1);

        // Flush while idle has no effect on the following miss.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("idle_flush_busy", {63'd0, busy}, 64'd0);
        bus_req(64'h8000_000C, 1'b0, 64'h8000_0008, 6'd1, 0, 1, 64'hFEDC_BA98_7654_3210, 2'b00, 0);

        // Reset asserted while in R; a late beat must be ignored.
        ar_q.push_back(64'h8000_0300);
        miss = 1'b1; sram_addr = 64'h8000_0300; lru = 1'b1;
        tick();
        miss = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("rstR_rready_before", {63'd0, rready}, 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstR_rready", {63'd0, rready}, 64'd0);
        chk("rstR_busy", {63'd0, busy}, 64'd0);
        chk("rstR_araddr", araddr, 64'd0);
        chk("rstR_arvalid", {63'd0, arvalid}, 64'd0);
        rvalid = 1'b1; rdata = 64'h0BAD_0BAD_0BAD_0BAD; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        chk("late_busy", {63'd0, busy}, 64'd0);
        chk("late_refresh", {63'd0, refresh}, 64'd0);
        chk("late_wdata", data_wdata, 64'd0);
        repeat (3) tick();
        chk("late_refresh2", {63'd0, refresh}, 64'd0);

        chk("ar_q_empty", 64'(ar_q.size()), 64'd0);
        chk("ev_q_empty", 64'(ev_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
